// File: rtl/fp4_vec_feeder.sv
// fp4_vec_feeder: takes packed A/B words of FP4 operands and emits one
// (a, b) pair per cycle to the MAC. A length counter bounds each vector.
// The block pulses an accumulator clear before the first pair, flags the
// last pair, and pulses done when the vector is complete.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for i_start; i_len latched on acceptance
// S_CLEAR | one-cycle accumulator clear pulse
// S_LOAD  | word_ready high, waiting for a packed word pair
// S_SHIFT | one pair per cycle from the captured words
// S_DONE  | one-cycle done pulse, then back to idle
//
// All outputs are registered. Each output takes the value that belongs to
// the state being entered, so it is valid in the same cycle as that state.
module fp4_vec_feeder #(
    parameter int LANES = 4,
    parameter int LEN_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [LEN_W-1:0]   i_len,
    input  logic               i_word_valid,
    output logic               o_word_ready,
    input  logic [4*LANES-1:0] i_word_a,
    input  logic [4*LANES-1:0] i_word_b,
    output logic               o_data_valid,
    output logic [3:0]         o_a,
    output logic [3:0]         o_b,
    output logic               o_acc_clear,
    output logic               o_last,
    output logic               o_busy,
    output logic               o_done
);

    localparam int W      = 4 * LANES;
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t              state;
    logic [LEN_W-1:0]    rem;
    logic [LANE_W-1:0]   lane;
    logic [W-1:0]        sh_a;
    logic [W-1:0]        sh_b;

    // Sequencer with registered outputs. The shift registers hold the lanes
    // that have not been emitted yet; lane 0 is sent straight from the
    // captured word, so the remainder is stored pre-shifted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            rem          <= '0;
            lane         <= '0;
            sh_a         <= '0;
            sh_b         <= '0;
            o_word_ready <= 1'b0;
            o_data_valid <= 1'b0;
            o_a          <= 4'h0;
            o_b          <= 4'h0;
            o_acc_clear  <= 1'b0;
            o_last       <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            o_word_ready <= 1'b0;
            o_data_valid <= 1'b0;
            o_a          <= 4'h0;
            o_b          <= 4'h0;
            o_acc_clear  <= 1'b0;
            o_last       <= 1'b0;
            o_done       <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        rem    <= i_len;
                        o_busy <= 1'b1;
                        if (i_len == '0) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                        end else begin
                            state       <= S_CLEAR;
                            o_acc_clear <= 1'b1;
                        end
                    end
                end

                S_CLEAR: begin
                    state        <= S_LOAD;
                    o_word_ready <= 1'b1;
                end

                S_LOAD: begin
                    if (i_word_valid) begin
                        state        <= S_SHIFT;
                        lane         <= '0;
                        sh_a         <= i_word_a >> 4;
                        sh_b         <= i_word_b >> 4;
                        o_data_valid <= 1'b1;
                        o_a          <= i_word_a[3:0];
                        o_b          <= i_word_b[3:0];
                        o_last       <= (rem == LEN_W'(1));
                    end else begin
                        o_word_ready <= 1'b1;
                    end
                end

                S_SHIFT: begin
                    rem <= rem - LEN_W'(1);
                    if (rem == LEN_W'(1)) begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                    end else if (lane == LANE_W'(LANES - 1)) begin
                        state        <= S_LOAD;
                        o_word_ready <= 1'b1;
                    end else begin
                        lane         <= lane + LANE_W'(1);
                        sh_a         <= sh_a >> 4;
                        sh_b         <= sh_b >> 4;
                        o_data_valid <= 1'b1;
                        o_a          <= sh_a[3:0];
                        o_b          <= sh_b[3:0];
                        o_last       <= (rem == LEN_W'(2));
                    end
                end

                S_DONE: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end

                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp4_vec_feeder.sv
// Testbench for fp4_vec_feeder: directed scenarios plus randomized vectors
// checked against a pair-stream model built from the accepted words.
module tb_fp4_vec_feeder;

    localparam int LANES = 4;
    localparam int LEN_W = 8;
    localparam int W     = 4 * LANES;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_start;
    logic [LEN_W-1:0] i_len;
    logic             i_word_valid;
    logic             o_word_ready;
    logic [W-1:0]     i_word_a;
    logic [W-1:0]     i_word_b;
    logic             o_data_valid;
    logic [3:0]       o_a;
    logic [3:0]       o_b;
    logic             o_acc_clear;
    logic             o_last;
    logic             o_busy;
    logic             o_done;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] src_a[$];
    logic [W-1:0] src_b[$];

    fp4_vec_feeder #(.LANES(LANES), .LEN_W(LEN_W)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_len        (i_len),
        .i_word_valid (i_word_valid),
        .o_word_ready (o_word_ready),
        .i_word_a     (i_word_a),
        .i_word_b     (i_word_b),
        .o_data_valid (o_data_valid),
        .o_a          (o_a),
        .o_b          (o_b),
        .o_acc_clear  (o_acc_clear),
        .o_last       (o_last),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset;
        i_rst = 1'b1; i_start = 1'b0; i_len = '0; i_word_valid = 1'b0;
        i_word_a = '0; i_word_b = '0;
        tick; tick;
        n_vec++;
        if ({o_word_ready, o_data_valid, o_a, o_b, o_acc_clear, o_last, o_busy, o_done} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want all zero",
                     {o_word_ready, o_data_valid, o_a, o_b, o_acc_clear, o_last, o_busy, o_done});
        end
        i_rst = 1'b0;
        tick;
        n_vec++;
        if ({o_word_ready, o_data_valid, o_busy, o_done, o_acc_clear} !== 5'd0) begin
            n_err++;
            $display("FAIL idle_after_reset: got %b want 00000",
                     {o_word_ready, o_data_valid, o_busy, o_done, o_acc_clear});
        end
    endtask

    // Runs one vector. stall = LOAD cycles with valid low before each word
    // (random up to stall when rnd_stall). busy_cyc injects i_start mid-vector.
    task automatic run_vector(input int len, input int stall, input bit rnd_stall,
                              input int busy_cyc, input string name);
        logic [W-1:0] qa[$];
        logic [W-1:0] qb[$];
        logic [W-1:0] wa, wb;
        logic [3:0]   ea, eb;
        int c, pairs, clears, dones, last_cyc, done_cyc, prev_pair_cyc, xfer_cyc;
        int stall_left, budget, exp_done;
        bit prev_wait;
        pairs = 0; clears = 0; dones = 0; last_cyc = -1; done_cyc = -1;
        prev_pair_cyc = -10; xfer_cyc = -10; prev_wait = 1'b0;
        budget = 60 + len * (stall + 3);
        stall_left = rnd_stall ? $urandom_range(0, stall) : stall;

        i_start = 1'b1; i_len = LEN_W'(len); i_word_valid = 1'b0;
        tick;
        i_start = 1'b0;
        c = 1;
        while (c < budget) begin
            n_vec++;
            if (o_data_valid !== 1'b1 && (o_a !== 4'h0 || o_b !== 4'h0)) begin
                n_err++;
                $display("FAIL %s idle_zero c=%0d: a=%h b=%h want 0 0", name, c, o_a, o_b);
            end
            if (c == 1) begin
                n_vec++;
                if (o_busy !== 1'b1 || o_acc_clear !== (len != 0)) begin
                    n_err++;
                    $display("FAIL %s cycle1: busy=%b clear=%b want 1 %b", name, o_busy, o_acc_clear, len != 0);
                end
            end
            if (c == 2 && len != 0) begin
                n_vec++;
                if (o_word_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s ready_c2: got %b want 1", name, o_word_ready);
                end
            end
            if (len == 0 && (o_word_ready !== 1'b0 || o_data_valid !== 1'b0)) begin
                n_vec++; n_err++;
                $display("FAIL %s zero_len_activity c=%0d: ready=%b valid=%b want 0 0", name, c, o_word_ready, o_data_valid);
            end
            if (o_acc_clear === 1'b1) clears++;
            if (prev_wait) begin
                n_vec++;
                if (o_word_ready !== 1'b1 || o_data_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s stall_hold c=%0d: ready=%b valid=%b want 1 0", name, c, o_word_ready, o_data_valid);
                end
            end
            if (o_data_valid === 1'b1) begin
                n_vec++;
                if (pairs >= len || pairs / LANES >= qa.size()) begin
                    n_err++;
                    $display("FAIL %s extra_pair c=%0d: pair %0d with len %0d, %0d words", name, c, pairs, len, qa.size());
                end else begin
                    ea = 4'((qa[pairs / LANES] >> (4 * (pairs % LANES))) & 16'hF);
                    eb = 4'((qb[pairs / LANES] >> (4 * (pairs % LANES))) & 16'hF);
                    if (o_a !== ea || o_b !== eb || o_last !== (pairs == len - 1)) begin
                        n_err++;
                        $display("FAIL %s pair%0d: a=%h b=%h last=%b want %h %h %b",
                                 name, pairs, o_a, o_b, o_last, ea, eb, pairs == len - 1);
                    end
                    n_vec++;
                    if (c != ((pairs % LANES == 0) ? xfer_cyc + 1 : prev_pair_cyc + 1)) begin
                        n_err++;
                        $display("FAIL %s pair%0d_timing: cycle %0d want %0d", name, pairs, c,
                                 (pairs % LANES == 0) ? xfer_cyc + 1 : prev_pair_cyc + 1);
                    end
                end
                prev_pair_cyc = c;
                if (o_last === 1'b1) last_cyc = c;
                pairs++;
            end else if (o_last !== 1'b0) begin
                n_vec++; n_err++;
                $display("FAIL %s last_without_valid c=%0d: last=%b want 0", name, c, o_last);
            end
            if (o_done === 1'b1) begin
                dones++;
                exp_done = (len == 0) ? 1 : last_cyc + 1;
                n_vec++;
                if (c != exp_done) begin
                    n_err++;
                    $display("FAIL %s done_cycle: got %0d want %0d", name, c, exp_done);
                end
                done_cyc = c;
            end
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                n_vec++;
                if (o_busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s busy_drop: got %b want 0", name, o_busy);
                end
                break;
            end
            i_start = (c == busy_cyc);
            i_len   = (c == busy_cyc) ? LEN_W'(2) : LEN_W'(len);
            prev_wait = 1'b0;
            if (o_word_ready === 1'b1) begin
                if (stall_left > 0) begin
                    i_word_valid = 1'b0;
                    i_word_a = W'($urandom); i_word_b = W'($urandom);
                    stall_left--;
                    prev_wait = 1'b1;
                end else begin
                    if (src_a.size() > 0) begin
                        wa = src_a.pop_front(); wb = src_b.pop_front();
                    end else begin
                        wa = W'($urandom); wb = W'($urandom);
                    end
                    i_word_valid = 1'b1; i_word_a = wa; i_word_b = wb;
                    qa.push_back(wa); qb.push_back(wb);
                    xfer_cyc = c;
                    stall_left = rnd_stall ? $urandom_range(0, stall) : stall;
                end
            end else begin
                i_word_valid = 1'($urandom_range(0, 1));
                i_word_a = W'($urandom); i_word_b = W'($urandom);
            end
            tick;
            c++;
        end
        i_start = 1'b0; i_word_valid = 1'b0;
        n_vec++;
        if (c >= budget || pairs != len || clears != ((len != 0) ? 1 : 0) || dones != 1) begin
            n_err++;
            $display("FAIL %s totals: pairs=%0d clears=%0d dones=%0d cyc=%0d want %0d %0d 1 (<%0d)",
                     name, pairs, clears, dones, c, len, (len != 0) ? 1 : 0, budget);
        end
        for (int k = 0; k < 3; k++) begin
            tick;
            n_vec++;
            if ({o_busy, o_data_valid, o_done, o_acc_clear} !== 4'b0) begin
                n_err++;
                $display("FAIL %s post_idle: busy/valid/done/clear=%b want 0000", name,
                         {o_busy, o_data_valid, o_done, o_acc_clear});
            end
        end
    endtask

    task automatic test_single_word;
        src_a.push_back(16'h4321); src_b.push_back(16'h8765);
        run_vector(4, 0, 1'b0, -1, "single_word");
    endtask

    task automatic test_partial_word;
        src_a.push_back(16'h4321); src_b.push_back(16'h8765);
        src_a.push_back(16'hFEDC); src_b.push_back(16'hBA98);
        run_vector(6, 0, 1'b0, -1, "partial_word");
    endtask

    task automatic test_zero_len;
        run_vector(0, 0, 1'b0, -1, "zero_len");
    endtask

    task automatic test_backpressure;
        run_vector(8, 3, 1'b0, -1, "backpressure");
    endtask

    task automatic test_start_busy;
        run_vector(4, 0, 1'b0, 4, "start_busy");
    endtask

    task automatic test_reset_mid;
        i_start = 1'b1; i_len = LEN_W'(8); i_word_valid = 1'b1;
        tick;
        i_start = 1'b0;
        for (int c = 1; c < 4; c++) begin
            i_word_a = W'($urandom); i_word_b = W'($urandom);
            tick;
        end
        n_vec++;
        if (o_data_valid !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_pair2: valid=%b want 1", o_data_valid);
        end
        i_rst = 1'b1;
        tick;
        n_vec++;
        if ({o_word_ready, o_data_valid, o_a, o_b, o_acc_clear, o_last, o_busy, o_done} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got %b want all zero",
                     {o_word_ready, o_data_valid, o_a, o_b, o_acc_clear, o_last, o_busy, o_done});
        end
        i_rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick;
            n_vec++;
            if ({o_data_valid, o_done, o_busy, o_word_ready} !== 4'b0) begin
                n_err++;
                $display("FAIL reset_mid_quiet: valid/done/busy/ready=%b want 0000",
                         {o_data_valid, o_done, o_busy, o_word_ready});
            end
        end
        i_word_valid = 1'b0;
        src_a.push_back(16'h4321); src_b.push_back(16'h8765);
        run_vector(4, 0, 1'b0, -1, "after_reset");
    endtask

    task automatic test_random;
        int len;
        for (int v = 0; v < 30; v++) begin
            len = $urandom_range(1, 40);
            run_vector(len, 3, 1'b1, ($urandom_range(0, 3) == 0) ? $urandom_range(3, 8) : -1, "random");
        end
        run_vector(255, 1, 1'b1, -1, "max_len");
    endtask

    initial begin
        test_reset;
        test_single_word;
        test_partial_word;
        test_zero_len;
        test_backpressure;
        test_start_busy;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fp4_vec_feeder.md
# fp4_vec_feeder

Upstream operand feeder for the FP4 MAC. It accepts packed words of FP4 operands for A and B over a valid/ready handshake and serializes them into one (a, b) pair per cycle on the MAC's data-valid input. A length counter bounds each dot-product vector. The block pulses an accumulator clear before the first element and flags the last element and completion. The integrating top ORs `o_acc_clear` with system reset into the MAC reset, so each vector starts from a zero accumulator.

## Interface
- `LANES`, default 4: FP4 values per packed word. Legal range is 2..8.
- `LEN_W`, default 8: width of the vector length and the remaining-count counter.

- `i_clk`  input  1  clock; all logic is on the rising edge.
- `i_rst`  input  1  synchronous, active-high reset.
- `i_start`  input  1  begin a vector; sampled only in IDLE.
- `i_len`  input  LEN_W  number of element pairs in the vector; latched on accepted start.
- `i_word_valid`  input  1  packed word pair is available.
- `o_word_ready`  output  1  feeder accepts a word pair this cycle.
- `i_word_a`  input  4*LANES  packed A operands; lane k occupies bits [4k+3:4k].
- `i_word_b`  input  4*LANES  packed B operands, same lane layout.
- `o_data_valid`  output  1  `o_a`/`o_b` hold a valid pair; connects to the MAC `i_data_valid`.
- `o_a`  output  4  FP4 operand A.
- `o_b`  output  4  FP4 operand B.
- `o_acc_clear`  output  1  one-cycle accumulator clear pulse.
- `o_last`  output  1  asserted together with `o_data_valid` on the final pair.
- `o_busy`  output  1  high in every state except IDLE.
- `o_done`  output  1  one-cycle pulse when the vector is complete.

## Operation
- **States:** IDLE, CLEAR, LOAD, SHIFT, DONE.
- **IDLE:**
  - On `i_start`, latch `i_len` into `rem`.
  - If `i_len` == 0, go to DONE. Otherwise go to CLEAR.
- **CLEAR:** `o_acc_clear`=1 for exactly one cycle, then go to LOAD.
- **LOAD:**
  - `o_word_ready`=1.
  - On `i_word_valid` & `o_word_ready`, capture both words into the A and B shift registers, set `lane`=0, go to SHIFT.
  - Without valid, hold in LOAD indefinitely.
- **SHIFT (every cycle):**
  - `o_data_valid`=1.
  - `o_a`/`o_b` = lane `lane` of the captured words.
  - `rem` decrements.
  - If `rem`==1: `o_last`=1, go to DONE.
  - Else if `lane`==LANES-1: go to LOAD.
  - Else: `lane`++ and stay in SHIFT.
- **DONE:** `o_done`=1 for one cycle, then go to IDLE.
- **Partial final word:** when `i_len` is not a multiple of LANES, the unused upper lanes of the last word are discarded. No extra pairs are emitted.
- **Start while busy:** `i_start` outside IDLE is ignored. `i_len` is not re-sampled.
- **Word handshake outside LOAD:** `o_word_ready`=0, so no word is consumed.
- **Operand values:** the feeder does not interpret FP4 values; operands pass through bit-exact.
- **Output stability:** `o_a`/`o_b` are 0 whenever `o_data_valid`=0.
- **Counter widths:** `rem` is LEN_W bits; the maximum vector length is 2^LEN_W-1. `lane` is clog2(LANES) bits.

## Timing
- **Reset:**
  - `i_rst`=1 forces IDLE on the next edge and clears `rem`, `lane` and the shift registers.
  - All outputs go to 0: `o_word_ready`, `o_data_valid`, `o_a`, `o_b`, `o_acc_clear`, `o_last`, `o_busy`, `o_done`.
  - Reset mid-vector discards all buffered lanes. Nothing is emitted after reset until a new `i_start`.
- **Output timing:** all outputs are registered or derived from state registers only. No combinational path runs from inputs to outputs.
- **Normal start sequence:** `i_start` is accepted at cycle 0.
  - Cycle 1: `o_acc_clear`=1 and `o_busy`=1.
  - Cycle 2: `o_word_ready`=1.
  - If the word is valid at cycle 2, the first pair appears at cycle 3.
- **Throughput:** LANES pairs per LANES+1 cycles with no backpressure. Each LOAD costs a one-cycle bubble.
- **Completion:** `o_last` coincides with the final `o_data_valid`. `o_done` follows on the next cycle. `o_busy` drops the cycle after `o_done`, and IDLE accepts `i_start` then.
- **Zero length:** `i_len`=0 gives `o_done` at cycle 1. There is no clear, no ready and no data.
- **Clear-to-data spacing:** the clear pulse always precedes the first `o_data_valid` by at least 2 cycles. This lets the MAC reset settle.

## Test plan
- **Single word:** LANES=4, `i_len`=4, A=0x4321, B=0x8765, valid held high. Pairs (1,5), (2,6), (3,7), (4,8) appear on cycles 3-6. `o_last` is high with (4,8). `o_done` fires at cycle 7. `o_acc_clear` fires at cycle 1 only.
- **Partial last word:** `i_len`=6, words (0x4321, 0x8765) then (0xFEDC, 0xBA98). Exactly 6 pairs: 1/5, 2/6, 3/7, 4/8, C/8, D/9. There is a one-cycle bubble between words. Lanes E/A and F/B are never emitted. `o_last` is high with D/9.
- **Zero length:** `i_len`=0. `o_done` pulses at cycle 1. `o_acc_clear`, `o_word_ready` and `o_data_valid` stay 0 throughout.
- **Backpressure:** `i_word_valid` is low for 3 cycles while in LOAD. `o_word_ready` stays 1, `o_data_valid` stays 0. The first pair appears the cycle after valid rises.
- **Reset mid-vector:** `i_len`=8, reset asserted during the 2nd pair. All outputs are 0 the next cycle. There are no further pairs and no `o_done`. A new start with `i_len`=4 behaves exactly as in the single-word scenario.
- **Start while busy:** `i_start` pulsed with `i_len`=2 during SHIFT of an `i_len`=4 vector. It is ignored, the original 4 pairs complete, and only one `o_done` occurs.
